// File: rtl/pipe_hazard_ctrl.sv
// Run/stall/flush controller for the five-stage pipeline: a two-entry EX/MEM
// destination scoreboard drives RAW stalls, taken branches squash IF/ID and ID.
module pipe_hazard_ctrl #(
    parameter int REG_BITS = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_we,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                ex_branch_taken,
    input  logic                if_end,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                ifid_flush,
    output logic                idex_bubble,
    output logic                busy,
    output logic                done,
    output logic [CNT_BITS-1:0] stall_cnt
);

    // state | meaning
    // IDLE  | out of reset, waiting for start
    // RUN   | fetching and issuing
    // DRAIN | fetch stopped, in-flight instructions retiring
    // HALT  | program complete, pipeline empty
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    logic [1:0]          state;
    logic [1:0]          stateNext;
    logic                exValid;
    logic                memValid;
    logic [REG_BITS-1:0] exRd;
    logic [REG_BITS-1:0] memRd;
    logic [CNT_BITS-1:0] stallCnt;
    logic                active;
    logic                rsMatch;
    logic                rtMatch;
    logic                hazard;
    logic                issueWrite;
    logic                startAccept;
    logic                sbEmpty;
    logic                countStall;

    assign active = (state == RUN) || (state == DRAIN);

    // r0 is hard-wired zero, so a pending write to it never blocks a reader.
    assign rsMatch = (id_rs != '0) &&
                     ((exValid && (exRd == id_rs)) || (memValid && (memRd == id_rs)));
    assign rtMatch = (id_rt != '0) &&
                     ((exValid && (exRd == id_rt)) || (memValid && (memRd == id_rt)));

    assign hazard      = active && id_valid &&
                         ((id_use_rs && rsMatch) || (id_use_rt && rtMatch));
    assign issueWrite  = id_valid && id_we && !hazard && !ex_branch_taken;
    assign startAccept = !active && start;
    assign sbEmpty     = !exValid && !memValid;
    assign countStall  = active && hazard && !ex_branch_taken;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, HALT: if (start) stateNext = RUN;
            RUN:        if (if_end) stateNext = DRAIN;
            DRAIN:      if (sbEmpty && !id_valid) stateNext = HALT;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // WB is not tracked: the register file writes before ID reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid  <= 1'b0;
            exRd     <= '0;
            memValid <= 1'b0;
            memRd    <= '0;
        end else if (!active) begin
            exValid  <= 1'b0;
            exRd     <= '0;
            memValid <= 1'b0;
            memRd    <= '0;
        end else begin
            memValid <= exValid;
            memRd    <= exRd;
            exValid  <= issueWrite;
            exRd     <= id_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (startAccept) begin
            stallCnt <= '0;
        end else if (countStall && (stallCnt != '1)) begin
            stallCnt <= stallCnt + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    // Branch beats hazard: the stalled ID instruction is squashed anyway.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (active) begin
            if (ex_branch_taken) begin
                pc_en       = (state == RUN);
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (hazard) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                ifid_flush  = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                pc_en       = (state == RUN);
                ifid_en     = 1'b1;
                ifid_flush  = (state == DRAIN);
                idex_bubble = 1'b0;
            end
        end
    end

    assign busy      = active;
    assign done      = (state == HALT);
    assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a pending-write model.
module tb_pipe_hazard_ctrl;

    localparam int REG_BITS = 4;
    localparam int CNT_W    = 10;
    localparam int MAX_CNT  = (1 << CNT_W) - 1;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic                id_valid;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                id_use_rs;
    logic                id_use_rt;
    logic                id_we;
    logic [REG_BITS-1:0] id_rd;
    logic                ex_branch_taken;
    logic                if_end;
    logic                pc_en;
    logic                ifid_en;
    logic                ifid_flush;
    logic                idex_bubble;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    stall_cnt;

    int nCompared;
    int nMismatched;

    pipe_hazard_ctrl #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_we(id_we), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .if_end(if_end),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .busy(busy), .done(done),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nCompared = nCompared + 1;
        if (act != exp) begin
            nMismatched = nMismatched + 1;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each issued write is pending for two cycles (EX, then MEM).
    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_HALT} mode_t;
    typedef struct {int rd; int left;} pend_t;

    mode_t mode;
    pend_t pendQ[$];
    int    modelCnt;

    function automatic bit inFlight(input logic [REG_BITS-1:0] r);
        if (r == '0) return 1'b0;
        foreach (pendQ[i]) if (pendQ[i].rd == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        bit    act;
        bit    haz;
        bit    empty;
        int    ePc, eEn, eFl, eBb;
        pend_t nq[$];
        mode = M_IDLE;
        modelCnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mode = M_IDLE;
                pendQ.delete();
                modelCnt = 0;
            end
            act = (mode == M_RUN) || (mode == M_DRAIN);
            haz = act && id_valid &&
                  ((id_use_rs && inFlight(id_rs)) || (id_use_rt && inFlight(id_rt)));
            if (!act) begin
                ePc = 0; eEn = 0; eFl = 1; eBb = 1;
            end else if (ex_branch_taken) begin
                ePc = (mode == M_RUN); eEn = 1; eFl = 1; eBb = 1;
            end else if (haz) begin
                ePc = 0; eEn = 0; eFl = 0; eBb = 1;
            end else begin
                ePc = (mode == M_RUN); eEn = 1; eFl = (mode == M_DRAIN); eBb = 0;
            end
            chk("pc_en", pc_en, ePc);
            chk("ifid_en", ifid_en, eEn);
            chk("ifid_flush", ifid_flush, eFl);
            chk("idex_bubble", idex_bubble, eBb);
            chk("busy", busy, act);
            chk("done", done, mode == M_HALT);
            chk("stall_cnt", stall_cnt, modelCnt);
            if (rst_n) begin
                if (!act) begin
                    pendQ.delete();
                    if (start) begin
                        mode = M_RUN;
                        modelCnt = 0;
                    end
                end else begin
                    empty = (pendQ.size() == 0);
                    if (haz && !ex_branch_taken && modelCnt < MAX_CNT) modelCnt++;
                    nq.delete();
                    foreach (pendQ[i]) if (pendQ[i].left > 1) nq.push_back('{pendQ[i].rd, pendQ[i].left - 1});
                    pendQ = nq;
                    if (id_valid && id_we && !haz && !ex_branch_taken)
                        pendQ.push_back('{int'(id_rd), 2});
                    if (mode == M_RUN && if_end) mode = M_DRAIN;
                    else if (mode == M_DRAIN && empty && !id_valid) mode = M_HALT;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic setInst(input bit v, input logic [REG_BITS-1:0] rs, input bit urs,
                           input logic [REG_BITS-1:0] rt, input bit urt,
                           input bit we, input logic [REG_BITS-1:0] rd);
        id_valid = v; id_rs = rs; id_use_rs = urs;
        id_rt = rt; id_use_rt = urt; id_we = we; id_rd = rd;
    endtask

    task automatic clrIn();
        start = 1'b0; ex_branch_taken = 1'b0; if_end = 1'b0;
        setInst(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        rst_n = 1'b0;
        clrIn();

        // reset values
        tick(); tick(); settle();
        chk("rst_pc_en", pc_en, 0);
        chk("rst_ifid_en", ifid_en, 0);
        chk("rst_ifid_flush", ifid_flush, 1);
        chk("rst_idex_bubble", idex_bubble, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        tick(); rst_n = 1'b1;

        // back-to-back RAW on r3
        tick(); start = 1'b1; settle();
        chk("start_busy_before", busy, 0);
        tick(); start = 1'b0; setInst(1, 0, 0, 0, 0, 1, 3); settle();
        chk("run_busy", busy, 1);
        chk("run_pc_en", pc_en, 1);
        chk("run_bubble", idex_bubble, 0);
        tick(); setInst(1, 3, 1, 0, 0, 0, 0); settle();
        chk("raw_ex_pc_en", pc_en, 0);
        chk("raw_ex_bubble", idex_bubble, 1);
        tick(); settle();
        chk("raw_mem_pc_en", pc_en, 0);
        chk("raw_mem_bubble", idex_bubble, 1);
        tick(); settle();
        chk("raw_issue_pc_en", pc_en, 1);
        chk("raw_stall_cnt", stall_cnt, 2);

        // one-gap RAW on r5 through rt
        tick(); setInst(1, 0, 0, 0, 0, 1, 5); settle();
        chk("gap_prod_pc_en", pc_en, 1);
        tick(); setInst(1, 1, 1, 0, 0, 0, 0); settle();
        chk("gap_indep_pc_en", pc_en, 1);
        tick(); setInst(1, 0, 0, 5, 1, 0, 0); settle();
        chk("gap_cons_pc_en", pc_en, 0);
        tick(); settle();
        chk("gap_issue_pc_en", pc_en, 1);
        chk("gap_stall_cnt", stall_cnt, 3);

        // r0 never matches
        tick(); setInst(1, 0, 0, 0, 0, 1, 0); settle();
        tick(); setInst(1, 0, 1, 0, 1, 0, 0); settle();
        chk("r0_pc_en", pc_en, 1);
        chk("r0_bubble", idex_bubble, 0);

        // hazard and taken branch in the same cycle
        tick(); setInst(1, 0, 0, 0, 0, 1, 7); settle();
        tick(); setInst(1, 7, 1, 0, 0, 1, 9); ex_branch_taken = 1'b1; settle();
        chk("br_flush", ifid_flush, 1);
        chk("br_bubble", idex_bubble, 1);
        chk("br_pc_en", pc_en, 1);
        tick(); ex_branch_taken = 1'b0; setInst(1, 9, 1, 0, 0, 0, 0); settle();
        chk("br_squashed_no_entry", pc_en, 1);
        chk("br_stall_cnt", stall_cnt, 3);

        // drain and completion
        tick(); setInst(1, 0, 0, 0, 0, 1, 2); if_end = 1'b1; settle();
        chk("end_pc_en", pc_en, 1);
        tick(); if_end = 1'b0; setInst(0, 0, 0, 0, 0, 0, 0); settle();
        chk("drain_pc_en", pc_en, 0);
        chk("drain_flush", ifid_flush, 1);
        chk("drain_busy", busy, 1);
        chk("drain_done1", done, 0);
        tick(); settle();
        chk("drain_done2", done, 0);
        tick(); settle();
        chk("drain_done3", done, 0);
        tick(); settle();
        chk("halt_done", done, 1);
        chk("halt_busy", busy, 0);

        // reset during a stall, then restart
        tick(); start = 1'b1;
        tick(); start = 1'b0; setInst(1, 0, 0, 0, 0, 1, 4);
        tick(); setInst(1, 4, 1, 0, 0, 0, 0); settle();
        chk("f_stall_pc_en", pc_en, 0);
        chk("f_cnt_cleared", stall_cnt, 0);
        tick(); settle();
        chk("f_cnt1", stall_cnt, 1);
        rst_n = 1'b0; settle();
        chk("f_rst_busy", busy, 0);
        chk("f_rst_cnt", stall_cnt, 0);
        chk("f_rst_flush", ifid_flush, 1);
        tick(); rst_n = 1'b1; clrIn();
        tick(); start = 1'b1;
        tick(); start = 1'b0; setInst(1, 0, 0, 0, 0, 1, 4); settle();
        chk("f_restart_busy", busy, 1);
        chk("f_restart_pc_en", pc_en, 1);

        // saturation; a start while busy must not clear the counter
        for (int i = 0; i < 3 * (MAX_CNT + 1) + 30; i++) begin
            tick();
            setInst(1, 1, 1, 0, 0, 1, 1);
            start = (i == 3 * (MAX_CNT + 1) + 25);
        end
        tick(); start = 1'b0; settle();
        chk("sat_stall_cnt", stall_cnt, MAX_CNT);
        chk("sat_busy", busy, 1);

        // randomized traffic
        tick(); clrIn(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst_n = ($urandom_range(0, 399) != 0);
            start = ($urandom_range(0, 29) == 0);
            if_end = ($urandom_range(0, 49) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            setInst($urandom_range(0, 99) < 85,
                    REG_BITS'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    REG_BITS'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, REG_BITS'($urandom_range(0, 3)));
        end
        tick(); clrIn(); rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
